// File: rtl/ifid_stage_reg.sv
// IF/ID pipeline register: captures the fetched instruction and PC+4 for decode.
// Supports decode-side hold, instruction kill, a valid bit, and saturating event counters.
module ifid_stage_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_stall,
    input  logic             in_flush,
    input  logic [31:0]      in_instruct,
    input  logic [31:0]      in_PC_plus4,
    output logic [31:0]      out_instruct,
    output logic [31:0]      out_PC_plus4,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_stall_cnt,
    output logic [CNT_W-1:0] out_flush_cnt
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

    state_e           state_r;
    state_e           state_s;
    logic [31:0]      instr_r;
    logic [31:0]      instr_s;
    logic [31:0]      pc_r;
    logic [31:0]      pc_s;
    logic             valid_r;
    logic             valid_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] stall_cnt_s;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] flush_cnt_s;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    // Next-state and next-register decode; flush always outranks stall.
    always_comb begin
        state_s     = state_r;
        instr_s     = instr_r;
        pc_s        = pc_r;
        valid_s     = valid_r;
        stall_cnt_s = stall_cnt_r;
        flush_cnt_s = flush_cnt_r;
        case (state_r)
            FILL: begin
                // The first fetch is always captured, so in_stall is not looked at here.
                state_s = RUN;
                pc_s    = in_PC_plus4;
                if (in_flush) begin
                    instr_s     = NOP_INSTR;
                    valid_s     = 1'b0;
                    flush_cnt_s = sat_inc(flush_cnt_r);
                end else begin
                    instr_s = in_instruct;
                    valid_s = 1'b1;
                end
            end
            RUN, STALL: begin
                if (in_flush) begin
                    // PC still advances so fetch resumes from the right address.
                    state_s     = RUN;
                    pc_s        = in_PC_plus4;
                    instr_s     = NOP_INSTR;
                    valid_s     = 1'b0;
                    flush_cnt_s = sat_inc(flush_cnt_r);
                end else if (in_stall) begin
                    state_s     = STALL;
                    stall_cnt_s = sat_inc(stall_cnt_r);
                end else begin
                    state_s = RUN;
                    pc_s    = in_PC_plus4;
                    instr_s = in_instruct;
                    valid_s = 1'b1;
                end
            end
            default: begin
                // Corrupted state: drop back to a clean fill with a bubble presented.
                state_s = FILL;
                instr_s = NOP_INSTR;
                pc_s    = RESET_PC;
                valid_s = 1'b0;
            end
        endcase
    end

    // Pipeline register and counters; reset clears everything without a clock.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r     <= FILL;
            instr_r     <= NOP_INSTR;
            pc_r        <= RESET_PC;
            valid_r     <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            instr_r     <= instr_s;
            pc_r        <= pc_s;
            valid_r     <= valid_s;
            stall_cnt_r <= stall_cnt_s;
            flush_cnt_r <= flush_cnt_s;
        end
    end

    assign out_instruct  = instr_r;
    assign out_PC_plus4  = pc_r;
    assign out_valid     = valid_r;
    assign out_stall_cnt = stall_cnt_r;
    assign out_flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_ifid_stage_reg.sv
// Scoreboard bench for ifid_stage_reg: the driver acts as the fetch stage and queues the
// expected register contents; an independent monitor pops and compares after each event.
module tb_ifid_stage_reg;

    localparam int          CNT_W = 6;
    localparam int          CMAX  = (1 << CNT_W) - 1;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_stall;
    logic             in_flush;
    logic [31:0]      in_instruct;
    logic [31:0]      in_PC_plus4;
    logic [31:0]      out_instruct;
    logic [31:0]      out_PC_plus4;
    logic             out_valid;
    logic [CNT_W-1:0] out_stall_cnt;
    logic [CNT_W-1:0] out_flush_cnt;

    typedef struct packed {
        logic [31:0]      instr;
        logic [31:0]      pc;
        logic             valid;
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] fcnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem[64];
    int          checks   = 0;
    int          failures = 0;

    // Reference model: what the register holds after the most recent event.
    logic [31:0] m_ins;
    logic [31:0] m_pc;
    logic        m_val;
    int          m_sc;
    int          m_fc;
    logic        m_first;

    ifid_stage_reg #(
        .RESET_PC (RPC),
        .NOP_INSTR(NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .in_clk       (clk),
        .in_rst_n     (rst_n),
        .in_stall     (in_stall),
        .in_flush     (in_flush),
        .in_instruct  (in_instruct),
        .in_PC_plus4  (in_PC_plus4),
        .out_instruct (out_instruct),
        .out_PC_plus4 (out_PC_plus4),
        .out_valid    (out_valid),
        .out_stall_cnt(out_stall_cnt),
        .out_flush_cnt(out_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ins   = NOP;
        m_pc    = RPC;
        m_val   = 1'b0;
        m_sc    = 0;
        m_fc    = 0;
        m_first = 1'b1;
    endtask

    task automatic push_exp();
        exp_t e;
        e.instr = m_ins;
        e.pc    = m_pc;
        e.valid = m_val;
        e.scnt  = CNT_W'(m_sc);
        e.fcnt  = CNT_W'(m_fc);
        exp_q.push_back(e);
    endtask

    // Drive fetch outputs for the coming edge and queue what the register must hold after it.
    task automatic apply(input logic st, input logic fl, input logic ovr,
                         input logic [31:0] oi, input logic [31:0] op);
        logic [31:0] fi;
        logic [31:0] fp;
        fp = ovr ? op : m_pc + 32'd4;
        fi = ovr ? oi : mem[m_pc[7:2]];
        in_stall    = st;
        in_flush    = fl;
        in_instruct = fi;
        in_PC_plus4 = fp;
        if (!rst_n) begin
            model_reset();
        end else if (fl) begin
            m_pc    = fp;
            m_ins   = NOP;
            m_val   = 1'b0;
            m_first = 1'b0;
            if (m_fc < CMAX) m_fc++;
        end else if (st && !m_first) begin
            if (m_sc < CMAX) m_sc++;
        end else begin
            m_pc    = fp;
            m_ins   = fi;
            m_val   = 1'b1;
            m_first = 1'b0;
        end
        push_exp();
    endtask

    task automatic step(input logic st, input logic fl);
        @(negedge clk);
        apply(st, fl, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step_ovr(input logic st, input logic fl,
                            input logic [31:0] oi, input logic [31:0] op);
        @(negedge clk);
        apply(st, fl, 1'b1, oi, op);
    endtask

    task automatic release_rst(input logic st, input logic fl);
        @(negedge clk);
        rst_n = 1'b1;
        apply(st, fl, 1'b0, 32'h0, 32'h0);
    endtask

    // Asynchronous reset landing between edges, held across one clock edge.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        model_reset();
        push_exp();
        rst_n = 1'b0;
        step(1'b1, 1'b1);
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at %0t: got=%h exp=%h", name, $time, got, want);
        end
    endtask

    // Monitor: every clock edge and every reset assertion presents a new register value.
    initial begin
        exp_t e;
        #2;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow at %0t: got=empty exp=entry", $time);
            end else begin
                e = exp_q.pop_front();
                cmp("out_instruct", out_instruct, e.instr);
                cmp("out_PC_plus4", out_PC_plus4, e.pc);
                cmp("out_valid", {31'd0, out_valid}, {31'd0, e.valid});
                cmp("out_stall_cnt", 32'(out_stall_cnt), 32'(e.scnt));
                cmp("out_flush_cnt", 32'(out_flush_cnt), 32'(e.fcnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog at %0t: got=timeout exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_000A;
        mem[1] = 32'h2009_000B;
        mem[3] = 32'h200A_000C;
        rst_n       = 1'b0;
        in_stall    = 1'b0;
        in_flush    = 1'b0;
        in_instruct = 32'h0;
        in_PC_plus4 = 32'h0;
        model_reset();
        push_exp();
        step(1'b0, 1'b0);

        // Fill A then B, then walk to C at PC+4 = 0x10 and hold it for three edges.
        release_rst(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Killed load, then flush and stall together while already stalled.
        step_ovr(1'b0, 1'b1, 32'h8C01_0004, 32'h0000_0020);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Drive both counters past saturation.
        repeat (CMAX + 4) step(1'b1, 1'b0);
        repeat (CMAX + 4) step(1'b0, 1'b1);

        // Reset mid-stall, then repeat the fill sequence; then a fill edge with stall asserted.
        step(1'b1, 1'b0);
        reset_mid();
        release_rst(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset_mid();
        release_rst(1'b1, 1'b0);
        step(1'b1, 1'b0);
        reset_mid();
        release_rst(1'b1, 1'b1);
        step(1'b0, 1'b0);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_mid();
                release_rst(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            end else begin
                step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 6) == 0));
            end
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
